lcd_scaler: RTL and testbench

- Parametrised display back-end between vga_controller and frame_buffer.
- Maps VGA raster coordinates onto the 160x144 Game Boy frame with an integer scale factor and a configurable window position.
- Issues frame-buffer read addresses, compensates for the buffer's read latency, applies a double-buffered DMG palette (BGP format) and a shade mode, and delays sync so RGB and sync stay aligned.
- Clocked by the VGA pixel clock; draw_x advances by one per clock during active video.

---
 rtl/lcd_scaler.sv | 192 +++++++++++++++++++
 tb/tb_lcd_scaler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scaler.sv
// Display back-end: maps VGA raster onto an integer-scaled 160x144 window, fetches
// frame-buffer pixels, applies a tear-free DMG palette and keeps sync aligned with RGB.
module lcd_scaler #(
  parameter int SCALE      = 2,
  parameter int X_OFFSET   = 160,
  parameter int Y_OFFSET   = 96,
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 144,
  parameter int RD_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic       display_en,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [7:0] fb_x,
  output logic [7:0] fb_y,
  input  logic [1:0] fb_pixel,
  input  logic       pal_wren,
  input  logic [7:0] pal_data,
  input  logic       shade_mode,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hs_out,
  output logic       vs_out,
  output logic       frame_done
);

  localparam int X_END = X_OFFSET + SRC_W * SCALE;
  localparam int Y_END = Y_OFFSET + SRC_H * SCALE;
  localparam int DLY   = RD_LATENCY + 1;

  localparam logic [1:0] SUB_MAX = 2'(SCALE - 1);
  localparam logic [7:0] X_MAX   = 8'(SRC_W - 1);
  localparam logic [7:0] Y_MAX   = 8'(SRC_H - 1);
  localparam logic [7:0] X_SENT  = 8'(SRC_W);
  localparam logic [7:0] Y_SENT  = 8'(SRC_H);

  if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
    $error("lcd_scaler: SCALE must be 1..4");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_lat
    $error("lcd_scaler: RD_LATENCY must be 1..3");
  end
  if (X_END > 640 || Y_END > 480) begin : g_bad_win
    $error("lcd_scaler: scaled window exceeds 640x480 raster");
  end
  if (SRC_W > 255 || SRC_H > 255) begin : g_bad_src
    $error("lcd_scaler: source size must leave room for the sentinel");
  end

  function automatic logic [11:0] shade_rgb(input logic grey, input logic [1:0] s);
    logic [11:0] c;
    c = 12'h000;
    case ({grey, s})
      3'b000:  c = {4'd13, 4'd15, 4'd13};
      3'b001:  c = {4'd9,  4'd11, 4'd9};
      3'b010:  c = {4'd5,  4'd7,  4'd5};
      3'b011:  c = {4'd1,  4'd3,  4'd1};
      3'b100:  c = {4'd15, 4'd15, 4'd15};
      3'b101:  c = {4'd10, 4'd10, 4'd10};
      3'b110:  c = {4'd5,  4'd5,  4'd5};
      default: c = {4'd0,  4'd0,  4'd0};
    endcase
    return c;
  endfunction

  int   dx, dy;
  logic h_win, v_win, in_win, x_last, last_pix;
  logic y_end_hit, y_end_q, commit;

  logic [1:0] x_sub, y_sub;
  logic [7:0] x_cnt, y_cnt;
  logic       last_p0;

  logic [7:0] pal_pending, pal_active;
  logic [1:0] shade_sel;

  logic [DLY-1:0] win_p, en_p, hs_p, vs_p;

  always_comb begin
    dx        = int'(draw_x);
    dy        = int'(draw_y);
    h_win     = (dx >= X_OFFSET) && (dx < X_END);
    v_win     = (dy >= Y_OFFSET) && (dy < Y_END);
    in_win    = display_en && h_win && v_win;
    x_last    = in_win && (dx == X_END - 1);
    last_pix  = in_win && (x_cnt == X_MAX) && (x_sub == SUB_MAX)
                       && (y_cnt == Y_MAX) && (y_sub == SUB_MAX);
    y_end_hit = (dy == Y_END);
    commit    = y_end_hit && !y_end_q;
  end

  // Source coordinate counters: sub-pixel counts replace division by SCALE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_sub <= '0;
      x_cnt <= '0;
      y_sub <= '0;
      y_cnt <= '0;
    end else begin
      if (!h_win) begin
        x_sub <= '0;
        x_cnt <= '0;
      end else if (in_win) begin
        if (x_sub == SUB_MAX) begin
          x_sub <= '0;
          x_cnt <= (x_cnt == X_MAX) ? 8'd0 : x_cnt + 8'd1;
        end else begin
          x_sub <= x_sub + 2'd1;
        end
      end

      if (!v_win || !vs_in) begin
        y_sub <= '0;
        y_cnt <= '0;
      end else if (x_last) begin
        if (y_sub == SUB_MAX) begin
          y_sub <= '0;
          y_cnt <= (y_cnt == Y_MAX) ? 8'd0 : y_cnt + 8'd1;
        end else begin
          y_sub <= y_sub + 2'd1;
        end
      end
    end
  end

  // Stage 0: frame-buffer address, sentinels outside the window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fb_x       <= X_SENT;
      fb_y       <= Y_SENT;
      last_p0    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fb_x       <= in_win ? x_cnt : X_SENT;
      fb_y       <= in_win ? y_cnt : Y_SENT;
      last_p0    <= last_pix;
      frame_done <= last_p0;
    end
  end

  // Palette commits on the first line below the window so a frame never mixes palettes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pal_pending <= 8'hE4;
      pal_active  <= 8'hE4;
      y_end_q     <= 1'b0;
    end else begin
      y_end_q <= y_end_hit;
      if (pal_wren) pal_pending <= pal_data;
      if (commit)   pal_active  <= pal_wren ? pal_data : pal_pending;
    end
  end

  // Stages 1..RD_LATENCY+1: control flags ride alongside the frame-buffer read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_p <= '0;
      en_p  <= '0;
      hs_p  <= '0;
      vs_p  <= '0;
    end else begin
      win_p <= {win_p[DLY-2:0], in_win};
      en_p  <= {en_p[DLY-2:0],  display_en};
      hs_p  <= {hs_p[DLY-2:0],  hs_in};
      vs_p  <= {vs_p[DLY-2:0],  vs_in};
    end
  end

  assign shade_sel = pal_active[{fb_pixel, 1'b0} +: 2];

  // Output stage: colour lookup and sync, aligned to the same clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else begin
      if (en_p[DLY-1] && win_p[DLY-1])
        {vga_r, vga_g, vga_b} <= shade_rgb(shade_mode, shade_sel);
      else
        {vga_r, vga_g, vga_b} <= 12'h000;
      hs_out <= hs_p[DLY-1];
      vs_out <= vs_p[DLY-1];
    end
  end

endmodule

// File: tb/tb_lcd_scaler.sv
// Bench for lcd_scaler: default instance (A) and a RD_LATENCY=3/SCALE=1 instance (B)
// share the raster; a per-instance scoreboard queue holds expected RGB/sync.
module tb_lcd_scaler;

  logic       clk;
  logic [9:0] draw_x, draw_y;
  logic       display_en, hs_in, vs_in;

  logic       reset_a_n, pal_wren_a, sm_a, hs_out_a, vs_out_a, fd_a;
  logic [7:0] fb_x_a, fb_y_a, pal_data_a;
  logic [1:0] fbpix_a;
  logic [3:0] r_a, g_a, b_a;

  logic       reset_b_n, pal_wren_b, sm_b, hs_out_b, vs_out_b, fd_b;
  logic [7:0] fb_x_b, fb_y_b, pal_data_b;
  logic [1:0] fbp_b1, fbp_b2, fbp_b3;
  logic [3:0] r_b, g_b, b_b;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  typedef struct {
    bit          chk;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  logic [7:0] pal_act_a, pal_pend_a;
  int         prev_y_a;

  lcd_scaler dut_a (
    .clock(clk), .reset_n(reset_a_n), .draw_x(draw_x), .draw_y(draw_y),
    .display_en(display_en), .hs_in(hs_in), .vs_in(vs_in),
    .fb_x(fb_x_a), .fb_y(fb_y_a), .fb_pixel(fbpix_a),
    .pal_wren(pal_wren_a), .pal_data(pal_data_a), .shade_mode(sm_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .hs_out(hs_out_a), .vs_out(vs_out_a), .frame_done(fd_a)
  );

  lcd_scaler #(.SCALE(1), .X_OFFSET(0), .Y_OFFSET(0), .RD_LATENCY(3)) dut_b (
    .clock(clk), .reset_n(reset_b_n), .draw_x(draw_x), .draw_y(draw_y),
    .display_en(display_en), .hs_in(hs_in), .vs_in(vs_in),
    .fb_x(fb_x_b), .fb_y(fb_y_b), .fb_pixel(fbp_b3),
    .pal_wren(pal_wren_b), .pal_data(pal_data_b), .shade_mode(sm_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .hs_out(hs_out_b), .vs_out(vs_out_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer models: pixel index is the low two bits of the column
  always_ff @(posedge clk) begin
    fbpix_a <= fb_x_a[1:0];
    fbp_b1  <= fb_x_b[1:0];
    fbp_b2  <= fbp_b1;
    fbp_b3  <= fbp_b2;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] tbl(input bit grey, input logic [1:0] s);
    logic [11:0] c;
    if (!grey)
      case (s)
        2'd0: c = {4'd13, 4'd15, 4'd13};
        2'd1: c = {4'd9, 4'd11, 4'd9};
        2'd2: c = {4'd5, 4'd7, 4'd5};
        default: c = {4'd1, 4'd3, 4'd1};
      endcase
    else
      case (s)
        2'd0: c = 12'hFFF;
        2'd1: c = 12'hAAA;
        2'd2: c = 12'h555;
        default: c = 12'h000;
      endcase
    return c;
  endfunction

  function automatic bit win(input int x, input int y, input bit en,
                             input int xo, input int yo, input int sc);
    return en && x >= xo && x < xo + 160 * sc && y >= yo && y < yo + 144 * sc;
  endfunction

  function automatic logic [11:0] exp_rgb(input int x, input int y, input bit en,
      input int xo, input int yo, input int sc, input bit grey, input logic [7:0] pal);
    int idx;
    if (!win(x, y, en, xo, yo, sc)) return 12'h000;
    idx = ((x - xo) / sc) % 4;
    return tbl(grey, pal[2*idx +: 2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ck: bit0 RGB/sync A, bit1 RGB/sync B, bit2 address A, bit3 address B
  task automatic step(input int x, input int y, input bit en, input bit hs, input bit vs,
                      input logic [3:0] ck);
    ent_t ea, eb;
    draw_x = x[9:0];
    draw_y = y[9:0];
    display_en = en;
    hs_in = hs;
    vs_in = vs;
    if (y == 384 && prev_y_a != 384) pal_act_a = pal_wren_a ? pal_data_a : pal_pend_a;
    if (pal_wren_a) pal_pend_a = pal_data_a;
    prev_y_a = y;
    ea = '{ck[0], exp_rgb(x, y, en, 160, 96, 2, sm_a, pal_act_a), hs, vs};
    eb = '{ck[1], exp_rgb(x, y, en, 0, 0, 1, sm_b, 8'hE4), hs, vs};
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #1;
    if (fd_a) fd_cnt++;
    if (qa.size() == 3) begin
      ea = qa.pop_front();
      if (ea.chk) begin
        chk("rgb_a", {r_a, g_a, b_a}, ea.rgb);
        chk("hs_a", hs_out_a, ea.hs);
        chk("vs_a", vs_out_a, ea.vs);
      end
    end
    if (qb.size() == 5) begin
      eb = qb.pop_front();
      if (eb.chk) begin
        chk("rgb_b", {r_b, g_b, b_b}, eb.rgb);
        chk("hs_b", hs_out_b, eb.hs);
        chk("vs_b", vs_out_b, eb.vs);
      end
    end
    if (ck[2]) begin
      chk("fbx_a", fb_x_a, win(x, y, en, 160, 96, 2) ? (x - 160) / 2 : 160);
      chk("fby_a", fb_y_a, win(x, y, en, 160, 96, 2) ? (y - 96) / 2 : 144);
    end
    if (ck[3]) begin
      chk("fbx_b", fb_x_b, win(x, y, en, 0, 0, 1) ? x : 160);
      chk("fby_b", fb_y_b, win(x, y, en, 0, 0, 1) ? y : 144);
    end
  endtask

  task automatic line(input int y, input int x0, input int x1, input bit en,
                      input logic [3:0] ck);
    for (int x = x0; x <= x1; x++) step(x, y, en, 1'b1, 1'b1, ck);
    for (int x = 700; x < 704; x++) step(x, y, 1'b0, 1'b0, 1'b1, ck);
  endtask

  // Short-cut frame for A: one window column per line until the final, fully scanned line
  task automatic frame_a(input bit wr, input logic [7:0] d);
    fd_cnt = 0;
    step(0, 0, 1'b0, 1'b1, 1'b0, 4'b0000);
    for (int y = 96; y < 383; y++) begin
      step(479, y, 1'b1, 1'b1, 1'b1, 4'b0000);
      step(0, y, 1'b0, 1'b0, 1'b1, 4'b0000);
    end
    for (int x = 156; x <= 483; x++) begin
      step(x, 383, 1'b1, 1'b1, 1'b1, 4'b0101);
      chk("frame_done", fd_a, (x == 480) ? 1 : 0);
    end
    pal_wren_a = wr;
    pal_data_a = d;
    step(0, 384, 1'b0, 1'b1, 1'b1, 4'b0101);
    pal_wren_a = 1'b0;
    for (int x = 1; x < 4; x++) step(x, 384, 1'b0, 1'b1, 1'b1, 4'b0101);
    chk("fd_count", fd_cnt, 1);
  endtask

  task automatic check_reset_a();
    chk("rst_fbx_a", fb_x_a, 160);
    chk("rst_fby_a", fb_y_a, 144);
    chk("rst_rgb_a", {r_a, g_a, b_a}, 0);
    chk("rst_hs_a", hs_out_a, 1);
    chk("rst_vs_a", vs_out_a, 1);
    chk("rst_fd_a", fd_a, 0);
  endtask

  initial begin
    draw_x = '0; draw_y = '0; display_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    pal_wren_a = 1'b0; pal_data_a = 8'h00; sm_a = 1'b0;
    pal_wren_b = 1'b0; pal_data_b = 8'h00; sm_b = 1'b1;
    pal_act_a = 8'hE4; pal_pend_a = 8'hE4; prev_y_a = 0;
    reset_a_n = 1'b0;
    reset_b_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a();
    chk("rst_fbx_b", fb_x_b, 160);
    chk("rst_fby_b", fb_y_b, 144);
    chk("rst_rgb_b", {r_b, g_b, b_b}, 0);
    chk("rst_hs_b", hs_out_b, 1);
    chk("rst_vs_b", vs_out_b, 1);
    reset_a_n = 1'b1;
    reset_b_n = 1'b1;

    // A: window edges, scaling and border with the identity palette
    step(700, 500, 1'b0, 1'b1, 1'b0, 4'b0000);
    for (int y = 90; y < 100; y++) line(y, 156, 483, 1'b1, 4'b0101);
    line(100, 156, 483, 1'b0, 4'b0101);

    // A: mid-frame palette write stays pending until the frame ends
    pal_wren_a = 1'b1;
    pal_data_a = 8'h1B;
    step(700, 101, 1'b0, 1'b0, 1'b1, 4'b0001);
    pal_wren_a = 1'b0;
    line(102, 156, 483, 1'b1, 4'b0001);
    frame_a(1'b0, 8'h00);
    line(96, 156, 483, 1'b1, 4'b0101);

    // A: write landing on the commit clock goes straight to the active palette
    frame_a(1'b1, 8'hFF);
    line(96, 156, 483, 1'b1, 4'b0101);

    // A: asynchronous reset in the middle of a line
    for (int x = 156; x < 300; x++) step(x, 200, 1'b1, 1'b1, 1'b1, 4'b0001);
    draw_x = 10'd300;
    draw_y = 10'd200;
    reset_a_n = 1'b0;
    #1;
    check_reset_a();
    qa.delete();
    pal_act_a = 8'hE4;
    pal_pend_a = 8'hE4;
    prev_y_a = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_a_n = 1'b1;
    for (int x = 301; x <= 483; x++) step(x, 200, 1'b1, 1'b1, 1'b1, 4'b0000);
    frame_a(1'b0, 8'h00);
    line(96, 156, 483, 1'b1, 4'b0101);

    // B: deeper read latency, unit scale, grey shades
    step(700, 500, 1'b0, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) step(701 + i, 500, 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int y = 0; y < 4; y++) line(y, 0, 165, 1'b1, 4'b1010);
    step(710, 500, 1'b0, 1'b0, 1'b0, 4'b1010);
    step(711, 500, 1'b0, 1'b1, 1'b0, 4'b1010);
    for (int x = 712; x < 720; x++) step(x, 500, 1'b0, 1'b1, 1'b1, 4'b1010);
    line(4, 0, 165, 1'b0, 4'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
